// File: rtl/even_divisor_monitor.sv
// even_divisor_monitor
//   Checks a divided clock against its expected even divide ratio, measuring
//   in cycles of the reference clock. div_in is treated as a data signal and
//   is sampled on clk through a two-flop synchroniser plus an edge register.
//   Every rise-to-rise period must be DIV cycles and every high phase DIV/2.
//   LOCK_CNT consecutive good periods assert locked. Any violation or a
//   missing rise (timeout at 2*DIV cycles) raises an error.
//
// Ports
//   clk          in   1      reference clock
//   rstn         in   1      asynchronous active-low reset
//   div_in       in   1      divided clock under check
//   clr_err      in   1      one-cycle pulse clearing err_sticky and err_cnt
//   locked       out  1      LOCK_CNT consecutive good periods, no error since
//   err_pulse    out  1      one-cycle pulse per detected violation
//   err_sticky   out  1      set on any violation, held until clr_err
//   err_cnt      out  ERR_W  saturating violation count
//   last_period  out  CNT_W  last measured rise-to-rise period in clk cycles
module even_divisor_monitor #(
   parameter int DIV      = 10,
   parameter int CNT_W    = 8,
   parameter int LOCK_CNT = 4,
   parameter int ERR_W    = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             div_in,
   input  logic             clr_err,
   output logic             locked,
   output logic             err_pulse,
   output logic             err_sticky,
   output logic [ERR_W-1:0] err_cnt,
   output logic [CNT_W-1:0] last_period
);

   localparam int GOOD_W = $clog2(LOCK_CNT + 1);

   localparam logic [CNT_W-1:0]  PMAX    = CNT_W'(2 * DIV);
   localparam logic [CNT_W-1:0]  PGOOD   = CNT_W'(DIV);
   localparam logic [CNT_W-1:0]  HGOOD   = CNT_W'(DIV / 2);
   localparam logic [GOOD_W-1:0] GOOD_LK = GOOD_W'(LOCK_CNT);
   localparam logic [GOOD_W-1:0] GOOD_PR = GOOD_W'(LOCK_CNT - 1);

   typedef enum logic [1:0] {
      IDLE,
      MEASURE,
      LOCKED
   } state_t;

   state_t state;
   state_t state_nxt;

   logic              s1;
   logic              s2;
   logic              s3;
   logic              rise;
   logic              fall;
   logic [CNT_W-1:0]  pcnt;
   logic [CNT_W-1:0]  hi_len;
   logic [GOOD_W-1:0] good;
   logic [GOOD_W-1:0] good_nxt;
   logic              err_cond;
   logic              upd_last;

   assign rise = s2 & ~s3;
   assign fall = ~s2 & s3;

   // Input path and period / high-phase measurement.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1     <= 1'b0;
         s2     <= 1'b0;
         s3     <= 1'b0;
         pcnt   <= '0;
         hi_len <= '0;
      end else begin
         s1 <= div_in;
         s2 <= s1;
         s3 <= s2;
         if (rise) begin
            pcnt <= CNT_W'(1);
         end else if (pcnt != PMAX) begin
            pcnt <= pcnt + 1'b1;
         end
         if (fall) begin
            hi_len <= pcnt;
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
         good  <= '0;
      end else begin
         state <= state_nxt;
         good  <= good_nxt;
      end
   end

   // Next state. On a rise pcnt still holds the completed period, since the
   // reload to 1 happens on the same edge. Timeout drops to IDLE so that it
   // cannot fire again until a fresh rise restarts measurement.
   always_comb begin
      state_nxt = state;
      good_nxt  = good;
      err_cond  = 1'b0;
      upd_last  = 1'b0;
      case (state)
         IDLE: begin
            if (rise) begin
               state_nxt = MEASURE;
               good_nxt  = '0;
            end
         end
         MEASURE, LOCKED: begin
            if (rise) begin
               upd_last = 1'b1;
               if ((pcnt == PGOOD) && (hi_len == HGOOD)) begin
                  if (good >= GOOD_PR) begin
                     good_nxt  = GOOD_LK;
                     state_nxt = LOCKED;
                  end else begin
                     good_nxt = good + 1'b1;
                  end
               end else begin
                  err_cond  = 1'b1;
                  state_nxt = MEASURE;
                  good_nxt  = '0;
               end
            end else if (pcnt == PMAX) begin
               err_cond  = 1'b1;
               state_nxt = IDLE;
               good_nxt  = '0;
            end
         end
         default: begin
            state_nxt = IDLE;
            good_nxt  = '0;
         end
      endcase
   end

   // Registered status outputs and error bookkeeping. A new error takes
   // precedence over a simultaneous clear, leaving a count of one.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         locked      <= 1'b0;
         err_pulse   <= 1'b0;
         err_sticky  <= 1'b0;
         err_cnt     <= '0;
         last_period <= '0;
      end else begin
         locked    <= (state_nxt == LOCKED);
         err_pulse <= err_cond;
         if (upd_last) begin
            last_period <= pcnt;
         end
         if (err_cond) begin
            err_sticky <= 1'b1;
            if (clr_err) begin
               err_cnt <= ERR_W'(1);
            end else if (err_cnt != '1) begin
               err_cnt <= err_cnt + 1'b1;
            end
         end else if (clr_err) begin
            err_sticky <= 1'b0;
            err_cnt    <= '0;
         end
      end
   end

endmodule

// File: tb/tb_even_divisor_monitor.sv
// tb_even_divisor_monitor
//   Self-checking bench for even_divisor_monitor. A behavioural model keeps
//   edge timestamps (cycle of last detected rise) and derives periods, high
//   lengths, lock and error status arithmetically from them.
module tb_even_divisor_monitor;

   localparam int DIV      = 10;
   localparam int CNT_W    = 8;
   localparam int LOCK_CNT = 4;
   localparam int ERR_W    = 8;

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic             div_in = 1'b0;
   logic             clr_err = 1'b0;
   logic             locked;
   logic             err_pulse;
   logic             err_sticky;
   logic [ERR_W-1:0] err_cnt;
   logic [CNT_W-1:0] last_period;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   even_divisor_monitor #(
      .DIV     (DIV),
      .CNT_W   (CNT_W),
      .LOCK_CNT(LOCK_CNT),
      .ERR_W   (ERR_W)
   ) dut (
      .clk        (clk),
      .rstn       (rstn),
      .div_in     (div_in),
      .clr_err    (clr_err),
      .locked     (locked),
      .err_pulse  (err_pulse),
      .err_sticky (err_sticky),
      .err_cnt    (err_cnt),
      .last_period(last_period)
   );

   // ---------------- reference model ----------------
   // n: index of the last clock edge since reset. last_rise: edge index of
   // the last detected rise (1 at reset so the count since reset is n).
   // samples: div_in as seen at recent edges; a rise is acted on when the
   // input was high two edges ago and low three edges ago.
   int         n;
   int         last_rise;
   int         good;
   bit         tracking;
   bit         m_locked;
   bit         m_err;
   bit         m_sticky;
   int         m_cnt;
   int         m_last;
   int         m_hi;
   bit         samples [3];

   int         t_pc;
   bit         t_rise;
   bit         t_fall;
   bit         t_err;
   int         t_good;
   bit         t_trk;
   bit         t_lk;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         n          <= 0;
         last_rise  <= 1;
         good       <= 0;
         tracking   <= 1'b0;
         m_locked   <= 1'b0;
         m_err      <= 1'b0;
         m_sticky   <= 1'b0;
         m_cnt      <= 0;
         m_last     <= 0;
         m_hi       <= 0;
         samples[0] <= 1'b0;
         samples[1] <= 1'b0;
         samples[2] <= 1'b0;
      end else begin
         t_pc = (n + 1) - last_rise;
         if (t_pc > 2 * DIV) t_pc = 2 * DIV;
         t_rise = samples[1] && !samples[2];
         t_fall = !samples[1] && samples[2];
         t_err  = 1'b0;
         t_good = good;
         t_trk  = tracking;
         t_lk   = m_locked;
         if (t_rise) begin
            if (t_trk) begin
               m_last <= t_pc;
               if (t_pc == DIV && m_hi == DIV / 2) begin
                  t_good = t_good + 1;
                  if (t_good >= LOCK_CNT) t_lk = 1'b1;
               end else begin
                  t_err  = 1'b1;
                  t_good = 0;
                  t_lk   = 1'b0;
               end
            end else begin
               t_trk  = 1'b1;
               t_good = 0;
            end
            last_rise <= n + 1;
         end else if (t_trk && t_pc == 2 * DIV) begin
            t_err  = 1'b1;
            t_trk  = 1'b0;
            t_good = 0;
            t_lk   = 1'b0;
         end
         if (t_fall) m_hi <= t_pc;
         if (t_err) begin
            m_sticky <= 1'b1;
            if (clr_err) m_cnt <= 1;
            else if (m_cnt < (1 << ERR_W) - 1) m_cnt <= m_cnt + 1;
         end else if (clr_err) begin
            m_sticky <= 1'b0;
            m_cnt    <= 0;
         end
         good       <= t_good;
         tracking   <= t_trk;
         m_locked   <= t_lk;
         m_err      <= t_err;
         n          <= n + 1;
         samples[0] <= div_in;
         samples[1] <= samples[0];
         samples[2] <= samples[1];
      end
   end

   int dut_pulses = 0;
   int mdl_pulses = 0;
   always @(negedge clk) begin
      if (err_pulse === 1'b1) dut_pulses++;
      if (m_err) mdl_pulses++;
   end

   // Inputs change on the falling edge, away from the sampling edge.
   task automatic wave(input int hi, input int lo);
      div_in = 1'b1;
      repeat (hi) @(negedge clk);
      div_in = 1'b0;
      repeat (lo) @(negedge clk);
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      div_in = 1'b0;
      clr_err = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({locked, err_pulse, err_sticky} !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 000", {locked, err_pulse, err_sticky});
      end
      checks++;
      if (err_cnt !== '0 || last_period !== '0) begin
         errors++;
         $display("FAIL reset_counts: got cnt=%0d last=%0d expected 0 0", err_cnt, last_period);
      end
      rstn = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_lock();
      repeat (4) wave(5, 5);
      checks++;
      if (locked !== 1'b0) begin
         errors++;
         $display("FAIL lock_early: got %b expected 0 after 4 rises", locked);
      end
      div_in = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         checks++;
         if (locked !== (k == 3)) begin
            errors++;
            $display("FAIL lock_timing edge %0d: got %b expected %b", k, locked, (k == 3));
         end
      end
      repeat (2) @(negedge clk);
      div_in = 1'b0;
      repeat (5) @(negedge clk);
      wave(5, 5);
      checks++;
      if (locked !== 1'b1 || last_period !== 8'd10 || err_cnt !== '0) begin
         errors++;
         $display("FAIL lock_state: got lk=%b last=%0d cnt=%0d expected 1 10 0", locked, last_period, err_cnt);
      end
   endtask

   task automatic test_stretch();
      int p0;
      p0 = dut_pulses;
      wave(6, 6);
      wave(5, 5);
      checks++;
      if (dut_pulses - p0 !== 1 || err_cnt !== 8'd1 || locked !== 1'b0 || last_period !== 8'd12) begin
         errors++;
         $display("FAIL stretch: got pulses=%0d cnt=%0d lk=%b last=%0d expected 1 1 0 12",
                  dut_pulses - p0, err_cnt, locked, last_period);
      end
      repeat (3) wave(5, 5);
      checks++;
      if (locked !== 1'b0) begin
         errors++;
         $display("FAIL relock_early: got %b expected 0", locked);
      end
      wave(5, 5);
      checks++;
      if (locked !== 1'b1) begin
         errors++;
         $display("FAIL relock: got %b expected 1", locked);
      end
   endtask

   task automatic test_duty();
      wave(6, 4);
      wave(5, 5);
      checks++;
      if (err_sticky !== 1'b1 || last_period !== 8'd10 || err_cnt !== 8'd2 || locked !== 1'b0) begin
         errors++;
         $display("FAIL duty: got st=%b last=%0d cnt=%0d lk=%b expected 1 10 2 0",
                  err_sticky, last_period, err_cnt, locked);
      end
   endtask

   task automatic test_timeout();
      int p0;
      repeat (5) wave(5, 5);
      checks++;
      if (locked !== 1'b1) begin
         errors++;
         $display("FAIL timeout_prelock: got %b expected 1", locked);
      end
      p0 = dut_pulses;
      // Rise was acted on at edge 3 of the last wave, 7 edges before its end.
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (k >= 10 && k <= 16) begin
            checks++;
            if (err_pulse !== (k == 13)) begin
               errors++;
               $display("FAIL timeout_pulse k=%0d: got %b expected %b", k, err_pulse, (k == 13));
            end
         end
      end
      checks++;
      if (dut_pulses - p0 !== 1 || locked !== 1'b0 || err_cnt !== 8'd3) begin
         errors++;
         $display("FAIL timeout_once: got pulses=%0d lk=%b cnt=%0d expected 1 0 3",
                  dut_pulses - p0, locked, err_cnt);
      end
   endtask

   task automatic test_clr_collision();
      bit seen;
      seen = 1'b0;
      repeat (3) wave(5, 5);
      for (int k = 0; k < 60 && !seen; k++) begin
         clr_err = 1'b1;
         @(negedge clk);
         if (err_pulse === 1'b1) seen = 1'b1;
      end
      clr_err = 1'b0;
      checks++;
      if (!seen || err_sticky !== 1'b1 || err_cnt !== 8'd1) begin
         errors++;
         $display("FAIL clr_collision: got seen=%b st=%b cnt=%0d expected 1 1 1", seen, err_sticky, err_cnt);
      end
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      @(negedge clk);
      checks++;
      if (err_sticky !== 1'b0 || err_cnt !== '0) begin
         errors++;
         $display("FAIL clr_alone: got st=%b cnt=%0d expected 0 0", err_sticky, err_cnt);
      end
   endtask

   task automatic test_reset_mid();
      repeat (6) wave(5, 5);
      wave(7, 3);
      repeat (5) wave(5, 5);
      checks++;
      if (locked !== 1'b1 || err_sticky !== 1'b1 || err_cnt !== 8'd1) begin
         errors++;
         $display("FAIL premid: got lk=%b st=%b cnt=%0d expected 1 1 1", locked, err_sticky, err_cnt);
      end
      div_in = 1'b1;
      repeat (5) @(negedge clk);
      div_in = 1'b0;
      repeat (2) @(negedge clk);
      #2 rstn = 1'b0;
      #1;
      checks++;
      if ({locked, err_pulse, err_sticky} !== 3'b000 || err_cnt !== '0 || last_period !== '0) begin
         errors++;
         $display("FAIL reset_mid: got lk=%b ep=%b st=%b cnt=%0d last=%0d expected all 0",
                  locked, err_pulse, err_sticky, err_cnt, last_period);
      end
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      repeat (3) @(negedge clk);
      repeat (4) wave(5, 5);
      checks++;
      if (locked !== 1'b0) begin
         errors++;
         $display("FAIL reset_relock_early: got %b expected 0", locked);
      end
      wave(5, 5);
      checks++;
      if (locked !== 1'b1 || err_cnt !== '0) begin
         errors++;
         $display("FAIL reset_relock: got lk=%b cnt=%0d expected 1 0", locked, err_cnt);
      end
   endtask

   task automatic test_random();
      int hi;
      int lo;
      int r;
      int bad;
      bad = 0;
      for (int w = 0; w < 40; w++) begin
         r = int'($urandom_range(0, 9));
         if (r < 6) begin
            hi = DIV / 2;
            lo = DIV / 2;
         end else if (r < 9) begin
            hi = int'($urandom_range(1, 8));
            lo = int'($urandom_range(1, 8));
         end else begin
            hi = DIV / 2;
            lo = int'($urandom_range(20, 30));
         end
         for (int c = 0; c < hi + lo; c++) begin
            div_in  = (c < hi);
            clr_err = ($urandom_range(0, 15) == 0);
            @(negedge clk);
            checks++;
            if (locked !== m_locked || err_pulse !== m_err || err_sticky !== m_sticky ||
                err_cnt !== ERR_W'(m_cnt) || last_period !== CNT_W'(m_last)) begin
               errors++;
               bad++;
               if (bad <= 10)
                  $display("FAIL random w=%0d c=%0d: got lk=%b ep=%b st=%b cnt=%0d last=%0d expected %b %b %b %0d %0d",
                           w, c, locked, err_pulse, err_sticky, err_cnt, last_period,
                           m_locked, m_err, m_sticky, m_cnt, m_last);
            end
         end
      end
      clr_err = 1'b0;
      div_in  = 1'b0;
      @(negedge clk);
      checks++;
      if (dut_pulses !== mdl_pulses) begin
         errors++;
         $display("FAIL pulse_total: got %0d expected %0d", dut_pulses, mdl_pulses);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      test_reset();
      test_lock();
      test_stretch();
      test_duty();
      test_timeout();
      test_clr_collision();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
